wb_bus_arbiter: RTL

Round-robin arbiter that shares one WIDTH-bit write-back/data bus between three requesters and drives the 2-bit select of the 3:1 bus multiplexer. Each requester presents beats with a valid/last pair. The arbiter locks the bus to one owner from the first beat through the beat flagged last, then re-arbitrates. It sits between the three producer stages and the single downstream consumer, and replaces fixed select decoding wherever a shared port needs fair, packet-atomic access.

---
 rtl/wb_bus_arbiter_pkg.sv | 21 ++
 rtl/wb_bus_arbiter_mux3x1.sv | 22 ++
 rtl/wb_bus_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/wb_bus_arbiter_pkg.sv
// Shared encodings for the three-way round-robin bus arbiter.
// Holds the mux select codes, the FSM states and the ring-step helper.
package wb_bus_arbiter_pkg;

    localparam int NUM_REQ = 3;

    localparam logic [1:0] SEL_REQ0 = 2'b00;
    localparam logic [1:0] SEL_REQ1 = 2'b01;
    localparam logic [1:0] SEL_REQ2 = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Next requester index around the ring of three; code 11 never appears.
    function automatic logic [1:0] sel_inc(input logic [1:0] s);
        return (s == SEL_REQ2) ? SEL_REQ0 : s + 2'd1;
    endfunction

endpackage

// File: rtl/wb_bus_arbiter_mux3x1.sv
// Three-input data multiplexer steered by the arbiter's registered select.
module mux3X1
    import wb_bus_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] out_data
);

    always_comb begin
        case (sel)
            SEL_REQ1: out_data = in1;
            SEL_REQ2: out_data = in2;
            default:  out_data = in0;
        endcase
    end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Packet-atomic round-robin arbiter sharing one data bus between three requesters,
// with a forced release when the owner stays idle for TIMEOUT cycles.
module wb_bus_arbiter
    import wb_bus_arbiter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       req,
    input  logic [2:0]       last,
    input  logic [WIDTH-1:0] data_1,
    input  logic [WIDTH-1:0] data_2,
    input  logic [WIDTH-1:0] data_3,
    output logic [2:0]       ack,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic [1:0]       sel,
    output logic [2:0]       gnt,
    output logic             err
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    arb_state_e      state_q, state_d;
    logic [1:0]      sel_q, sel_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [2:0]      gnt_q, gnt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;

    logic            owner_req;
    logic            owner_last;
    logic            beat_ok;
    logic            final_beat;
    logic            timeout_hit;
    logic            release_grant;
    logic [1:0]      arb_ptr;
    logic [2:0]      arb_req;
    logic            pick_valid;
    logic [1:0]      pick_idx;

    // Returns {found, index} of the first set bit of r in the order p, p+1, p+2.
    function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
        logic       found;
        logic [1:0] cand;
        logic [1:0] win;
        found = 1'b0;
        win   = SEL_REQ0;
        cand  = p;
        for (int o = 0; o < NUM_REQ; o++) begin
            if (!found && r[cand]) begin
                found = 1'b1;
                win   = cand;
            end
            cand = sel_inc(cand);
        end
        return {found, win};
    endfunction

    assign owner_req     = |(req & gnt_q);
    assign owner_last    = |(last & gnt_q);
    assign beat_ok       = owner_req & out_ready;
    assign final_beat    = beat_ok & owner_last;
    assign timeout_hit   = (state_q == GRANT) && !owner_req && (cnt_q == CW'(TIMEOUT - 1));
    assign release_grant = final_beat | timeout_hit;
    assign arb_ptr       = release_grant ? sel_inc(sel_q) : ptr_q;
    // The owner's bit during its final beat is the beat being consumed, not a new request.
    assign arb_req       = req & ~gnt_q;
    assign {pick_valid, pick_idx} = rr_pick(arb_req, arb_ptr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= SEL_REQ0;
            ptr_q   <= SEL_REQ0;
            gnt_q   <= 3'b000;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pick_valid) begin
                    state_d = GRANT;
                    sel_d   = pick_idx;
                    gnt_d   = 3'b001 << pick_idx;
                end
            end
            GRANT: begin
                if (release_grant) begin
                    ptr_d = arb_ptr;
                    cnt_d = '0;
                    err_d = timeout_hit;
                    if (pick_valid) begin
                        sel_d = pick_idx;
                        gnt_d = 3'b001 << pick_idx;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 3'b000;
                    end
                end else begin
                    cnt_d = owner_req ? '0 : cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid = owner_req;
        out_last  = owner_req & owner_last;
        ack       = gnt_q & {3{beat_ok}};
        gnt       = gnt_q;
        sel       = sel_q;
        err       = err_q;
    end

    mux3X1 #(.WIDTH(WIDTH)) u_mux (
        .sel      (sel_q),
        .in0      (data_1),
        .in1      (data_2),
        .in2      (data_3),
        .out_data (out_data)
    );

endmodule
